// File: rtl/nibble_serial_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_cla_adder
//  Description : W-bit adder (W = 4*NIBBLES) that evaluates one nibble per
//                clock through a single 4-bit carry-lookahead slice, using a
//                start/busy/done handshake. The result is held until the next
//                operation completes.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_cla_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   Cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   Sum,
    output logic                   Cout,
    output logic                   Ovf
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IDXW-1:0]   r_idx;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_psum;
    logic              r_carry;

    logic              w_accept;
    logic              w_last;
    logic [3:0]        w_an;
    logic [3:0]        w_bn;
    logic [3:0]        w_g;
    logic [3:0]        w_p;
    logic [4:0]        w_c;
    logic [3:0]        w_snib;
    logic [W-1:0]      w_psum_next;

    // A new operation may begin from IDLE or in the single DONE cycle.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_idx == IDXW'(NIBBLES - 1));

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    // Select the nibble currently being processed from the shadow operands.
    assign w_an = r_a[{r_idx, 2'b00} +: 4];
    assign w_bn = r_b[{r_idx, 2'b00} +: 4];

    // 4-bit carry-lookahead slice; the slice carry-in is the inter-nibble carry.
    assign w_g    = w_an & w_bn;
    assign w_p    = w_an ^ w_bn;
    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_snib = w_p ^ w_c[3:0];

    // Partial sum with the current nibble merged in.
    always_comb begin
        w_psum_next = r_psum;
        w_psum_next[{r_idx, 2'b00} +: 4] = w_snib;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: RUN lasts NIBBLES cycles, DONE exactly one.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture, nibble-serial accumulation and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            Sum     <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_idx   <= '0;
            r_psum  <= '0;
        end else if (r_state == S_RUN) begin
            r_psum  <= w_psum_next;
            r_carry <= w_c[4];
            if (w_last) begin
                r_idx <= '0;
                Sum   <= w_psum_next;
                Cout  <= w_c[4];
                Ovf   <= w_c[3] ^ w_c[4];
            end else begin
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_cla_adder
//  Description : Self-checking bench for nibble_serial_cla_adder; directed
//                corner cases plus randomized operations against a plain
//                arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_cla_adder;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;
    localparam int TMO = 3 * NIB + 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          Cin   = 1'b0;
    logic [W-1:0]  A     = '0;
    logic [W-1:0]  B     = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  Sum;
    logic          Cout;
    logic          Ovf;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_cla_adder #(.NIBBLES(NIB)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from integer addition and sign rules.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin);
        logic [W:0] t;
        logic       ovf;
        t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return {ovf, t};
    endfunction

    // Wait (bounded) for done; returns the number of edges taken.
    task automatic wait_done(input string tag, input logic [W-1:0] held, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < TMO) begin
            check({tag, " hold"}, 64'(Sum), 64'(held));
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [W+1:0] e);
        check({tag, " sum"},  64'(Sum),  64'(e[W-1:0]));
        check({tag, " cout"}, 64'(Cout), 64'(e[W]));
        check({tag, " ovf"},  64'(Ovf),  64'(e[W+1]));
    endtask

    // One complete operation with operand scrambling after acceptance.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input string tag);
        logic [W+1:0] e;
        logic [W-1:0] prev;
        int           lat;
        e = ref_add(a, b, cin);
        @(negedge clk);
        A = a; B = b; Cin = cin; start = 1'b1;
        prev = Sum;
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
        check({tag, " busy"}, 64'(busy), 64'(1));
        wait_done(tag, prev, lat);
        check({tag, " lat"}, 64'(lat), 64'(NIB));
        check({tag, " busy@done"}, 64'(busy), 64'(0));
        check_result(tag, e);
        @(posedge clk); #1;
        check({tag, " done pulse"}, 64'(done), 64'(0));
        check({tag, " held"}, 64'(Sum), 64'(e[W-1:0]));
    endtask

    initial begin
        logic [W+1:0] e1;
        logic [W+1:0] e2;
        int           lat;
        int           seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst sum",  64'(Sum),  64'(0));
        check("rst cout", 64'(Cout), 64'(0));
        check("rst ovf",  64'(Ovf),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        op(16'h1234, 16'h4321, 1'b0, "t1");
        op(16'hFFFF, 16'h0001, 1'b0, "t2");
        op(16'h7FFF, 16'h0001, 1'b0, "t3a");
        op(16'h8000, 16'h8000, 1'b0, "t3b");
        op(16'h0000, 16'hFFFF, 1'b1, "t4a");
        op(16'h0F0F, 16'h1234, 1'b0, "t4b");
        check("t4b literal", 64'(Sum), 64'h2143);

        // start pulsed during RUN is ignored
        e1 = ref_add(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 16'hAAAA; B = 16'hAAAA; Cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        check_result("t5a", e1);
        @(posedge clk); #1;
        check("t5a no restart busy", 64'(busy), 64'(0));
        check("t5a no restart done", 64'(done), 64'(0));

        // start held high: back-to-back acceptance in the DONE cycle
        e1 = ref_add(16'h0101, 16'h0202, 1'b1);
        e2 = ref_add(16'hC3A5, 16'h5A3C, 1'b0);
        @(negedge clk);
        A = 16'h0101; B = 16'h0202; Cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        A = 16'hC3A5; B = 16'h5A3C; Cin = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t5b lat1", 64'(lat), 64'(NIB));
        check_result("t5b op1", e1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                check("t5b rebusy", 64'(busy), 64'(1));
                start = 1'b0;
                A = W'($urandom); B = W'($urandom);
            end
        end while (done !== 1'b1 && lat < TMO);
        check("t5b done spacing", 64'(lat), 64'(NIB + 1));
        check_result("t5b op2", e2);

        // Reset asserted during the second RUN cycle
        @(negedge clk);
        A = 16'h1234; B = 16'h4321; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t6 busy", 64'(busy), 64'(0));
        check("t6 done", 64'(done), 64'(0));
        check("t6 sum",  64'(Sum),  64'(0));
        check("t6 cout", 64'(Cout), 64'(0));
        check("t6 ovf",  64'(Ovf),  64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (2 * NIB) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        check("t6 no done", 64'(seen), 64'(0));
        check("t6 sum stays 0", 64'(Sum), 64'(0));
        op(16'hBEEF, 16'h1357, 1'b1, "t6 fresh");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
